// File: rtl/data_bus_responder.sv
// Data-port responder: word RAM + MMIO (TX FIFO, cycle counter, sticky errors); loads are zero-latency, stores commit at the edge.
// TX FIFO drains on tx_valid&tx_ready; a push into a full FIFO with no pop is dropped and flags overflow.
module data_bus_responder #(
  parameter int          DATA_DEPTH = 64,
  parameter logic [31:0] RAM_BASE   = 32'h1001_0000,
  parameter logic [31:0] IO_BASE    = 32'h1001_0400,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [31:0] data_address,
  input  logic [31:0] writedata,
  output logic [31:0] received_data,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_error
);

  localparam int          AW        = $clog2(DATA_DEPTH);
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DATA_DEPTH);
  localparam logic [PW:0] FULL_CNT  = (PW+1)'(FIFO_DEPTH);

  logic [31:0]   ram  [DATA_DEPTH];
  logic [31:0]   fifo [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic [31:0]   cycle;
  logic          overflow;

  logic [31:0]   ram_off;
  logic [AW-1:0] ram_idx;
  logic [1:0]    reg_sel;
  logic          ram_hit, io_hit, misaligned, addr_ok, ram_sel, io_sel;
  logic          access_err, ram_we, io_we, status_we;
  logic          empty, full, pop, push_req, push, ovf_set;

  assign ram_off    = data_address - RAM_BASE;
  assign ram_idx    = ram_off[AW+1:2];
  assign reg_sel    = data_address[3:2];
  assign ram_hit    = (data_address >= RAM_BASE) && (ram_off < RAM_BYTES);
  assign io_hit     = (data_address[31:4] == IO_BASE[31:4]);
  assign misaligned = |data_address[1:0];
  assign addr_ok    = !misaligned && (ram_hit || io_hit);
  assign ram_sel    = addr_ok && ram_hit;
  assign io_sel     = addr_ok && io_hit && !ram_hit;

  assign access_err = reset && (memread || memwrite) && !addr_ok;
  assign ram_we     = reset && memwrite && ram_sel;
  assign io_we      = reset && memwrite && io_sel;
  assign status_we  = io_we && (reg_sel == 2'd1);

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign pop      = !empty && tx_ready;
  assign push_req = io_we && (reg_sel == 2'd0);
  // A full FIFO still takes a word when the head leaves on the same edge.
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;

  assign tx_valid = !empty;
  assign tx_data  = empty ? 32'd0 : fifo[rd_ptr];

  always_comb begin
    received_data = 32'd0;
    if (reset && memread) begin
      if (ram_sel) begin
        received_data = ram[ram_idx];
      end else if (io_sel) begin
        case (reg_sel)
          2'd0:    received_data = 32'(count);
          2'd1:    received_data = {28'd0, overflow, bus_error, full, empty};
          2'd2:    received_data = cycle;
          default: received_data = 32'd0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= writedata;
    if (push)   fifo[wr_ptr] <= writedata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      cycle     <= 32'd0;
      overflow  <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      cycle <= (io_we && reg_sel == 2'd2) ? writedata : cycle + 32'd1;
      // Sticky flags: a set on the same edge beats a software clear.
      if (ovf_set)                        overflow  <= 1'b1;
      else if (status_we && writedata[3]) overflow  <= 1'b0;
      if (access_err)                     bus_error <= 1'b1;
      else if (status_we && writedata[2]) bus_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Bench for data_bus_responder: directed scenarios plus random traffic against a queue/array reference model.
module tb_data_bus_responder;
  localparam logic [31:0] RB = 32'h1001_0000;
  localparam logic [31:0] IB = 32'h1001_0400;
  localparam int DD = 64;
  localparam int FD = 8;

  logic clk = 1'b0;
  logic reset = 1'b0, memwrite = 1'b0, memread = 1'b0, tx_ready = 1'b0;
  logic [31:0] data_address = 32'd0, writedata = 32'd0;
  logic [31:0] received_data, tx_data;
  logic tx_valid, bus_error;

  int checks = 0;
  int errors = 0;

  data_bus_responder dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .memread(memread),
    .data_address(data_address), .writedata(writedata), .received_data(received_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] ram_m [DD];
  bit          ram_ok [DD];
  logic [31:0] q [$];
  logic [31:0] cyc_m = 32'd0;
  bit          ovf_m = 1'b0, berr_m = 1'b0;

  bit          exp_def;
  logic [31:0] exp_rd, exp_td, obs_rd, obs_td;
  logic        exp_tv, exp_be, obs_tv, obs_be;

  // 0 = unmapped or misaligned, 1 = RAM, 2 = MMIO
  function automatic int kind(input logic [31:0] a);
    if (a[1:0] != 2'b00) return 0;
    if (a >= RB && a < RB + 32'(4 * DD)) return 1;
    if (a[31:4] == IB[31:4]) return 2;
    return 0;
  endfunction

  task automatic model_edge(input logic mw, input logic mr, input logic [31:0] a,
                            input logic [31:0] wd, input logic rdy);
    int k, idx;
    bit full, pop, ovf_set, clr_ovf, clr_be;
    logic [31:0] nxt;
    if (!reset) begin
      q.delete();
      cyc_m = 32'd0; ovf_m = 1'b0; berr_m = 1'b0;
      return;
    end
    k = kind(a);
    idx = int'((a - RB) >> 2);
    full = (q.size() == FD);
    pop = (q.size() != 0) && rdy;
    ovf_set = 1'b0; clr_ovf = 1'b0; clr_be = 1'b0;
    nxt = cyc_m + 32'd1;
    if (mw && k == 1) begin ram_m[idx] = wd; ram_ok[idx] = 1'b1; end
    if (pop) void'(q.pop_front());
    if (mw && k == 2) begin
      case (a[3:2])
        2'd0: if (!full || pop) q.push_back(wd); else ovf_set = 1'b1;
        2'd1: begin clr_ovf = wd[3]; clr_be = wd[2]; end
        2'd2: nxt = wd;
        default: ;
      endcase
    end
    cyc_m = nxt;
    if (ovf_set) ovf_m = 1'b1; else if (clr_ovf) ovf_m = 1'b0;
    if ((mw || mr) && k == 0) berr_m = 1'b1; else if (clr_be) berr_m = 1'b0;
  endtask

  // One bus cycle: drive at negedge, capture outputs and model expectations, advance one edge.
  task automatic step(input logic mw, input logic mr, input logic [31:0] a,
                      input logic [31:0] wd, input logic rdy);
    int idx;
    memwrite = mw; memread = mr; data_address = a; writedata = wd; tx_ready = rdy;
    exp_def = 1'b1; exp_rd = 32'd0;
    if (reset && mr) begin
      case (kind(a))
        1: begin idx = int'((a - RB) >> 2); exp_def = ram_ok[idx]; exp_rd = ram_m[idx]; end
        2: case (a[3:2])
             2'd0: exp_rd = 32'(q.size());
             2'd1: exp_rd = {28'd0, ovf_m, berr_m, q.size() == FD, q.size() == 0};
             2'd2: exp_rd = cyc_m;
             default: exp_rd = 32'd0;
           endcase
        default: exp_rd = 32'd0;
      endcase
    end
    exp_tv = (q.size() != 0);
    exp_td = exp_tv ? q[0] : 32'd0;
    exp_be = berr_m;
    #1;
    obs_rd = received_data; obs_tv = tx_valid; obs_td = tx_data; obs_be = bus_error;
    @(posedge clk);
    model_edge(mw, mr, a, wd, rdy);
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    step(0, 1, IB + 4, 0, 1);
    step(0, 1, IB + 4, 0, 1);
    checks++; if (obs_rd !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h exp 0", obs_rd); end
    checks++; if (obs_tv !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b exp 0", obs_tv); end
    checks++; if (obs_td !== 32'd0) begin errors++; $display("FAIL reset_tx_data got %h exp 0", obs_td); end
    checks++; if (obs_be !== 1'b0) begin errors++; $display("FAIL reset_bus_error got %b exp 0", obs_be); end
    reset = 1'b1;
    step(0, 1, IB + 4, 0, 0);
    checks++; if (obs_rd !== 32'h1) begin errors++; $display("FAIL reset_status got %h exp 1", obs_rd); end
    step(0, 1, IB + 8, 0, 0);
    checks++; if (obs_rd !== 32'h1) begin errors++; $display("FAIL reset_cycle got %h exp 1", obs_rd); end
  endtask

  task automatic test_ram;
    step(1, 0, RB + 8, 32'hDEAD_BEEF, 0);
    step(0, 1, RB + 8, 0, 0);
    checks++; if (obs_rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_load got %h exp deadbeef", obs_rd); end
    step(1, 1, RB + 8, 32'h1234_5678, 0);
    checks++; if (obs_rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rw_old got %h exp deadbeef", obs_rd); end
    step(0, 1, RB + 8, 0, 0);
    checks++; if (obs_rd !== 32'h1234_5678) begin errors++; $display("FAIL ram_rw_new got %h exp 12345678", obs_rd); end
    step(0, 0, RB + 8, 0, 0);
    checks++; if (obs_rd !== 32'd0) begin errors++; $display("FAIL ram_noread got %h exp 0", obs_rd); end
    step(1, 0, RB + 4 * (DD - 1), 32'hCAFE_0001, 0);
    step(0, 1, RB + 4 * (DD - 1), 0, 0);
    checks++; if (obs_rd !== 32'hCAFE_0001) begin errors++; $display("FAIL ram_last got %h exp cafe0001", obs_rd); end
  endtask

  task automatic test_fifo_overflow;
    for (int i = 0; i < 9; i++) step(1, 0, IB, 32'hA000_0000 + 32'(i), 0);
    step(0, 1, IB + 4, 0, 0);
    checks++; if (obs_rd !== 32'hA) begin errors++; $display("FAIL ovf_status got %h exp a", obs_rd); end
    step(0, 1, IB, 0, 0);
    checks++; if (obs_rd !== 32'd8) begin errors++; $display("FAIL ovf_count got %0d exp 8", obs_rd); end
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 1);
      checks++;
      if (obs_tv !== 1'b1 || obs_td !== 32'hA000_0000 + 32'(i)) begin
        errors++; $display("FAIL drain_%0d got v=%b d=%h exp v=1 d=%h", i, obs_tv, obs_td, 32'hA000_0000 + 32'(i));
      end
    end
    step(0, 0, 0, 0, 1);
    checks++; if (obs_tv !== 1'b0 || obs_td !== 32'd0) begin errors++; $display("FAIL drained_empty got v=%b d=%h exp v=0 d=0", obs_tv, obs_td); end
    step(1, 0, IB + 4, 32'h8, 0);
    step(0, 1, IB + 4, 0, 0);
    checks++; if (obs_rd !== 32'h1) begin errors++; $display("FAIL ovf_clear got %h exp 1", obs_rd); end
  endtask

  task automatic test_full_push_pop;
    for (int i = 0; i < 8; i++) step(1, 0, IB, 32'hB000_0000 + 32'(i), 0);
    step(1, 0, IB, 32'hB000_0008, 1);
    checks++; if (obs_td !== 32'hB000_0000) begin errors++; $display("FAIL pp_head_before got %h exp b0000000", obs_td); end
    step(0, 1, IB, 0, 0);
    checks++; if (obs_rd !== 32'd8) begin errors++; $display("FAIL pp_count got %0d exp 8", obs_rd); end
    checks++; if (obs_td !== 32'hB000_0001) begin errors++; $display("FAIL pp_head_after got %h exp b0000001", obs_td); end
    step(0, 1, IB + 4, 0, 0);
    checks++; if (obs_rd !== 32'h2) begin errors++; $display("FAIL pp_status got %h exp 2", obs_rd); end
    for (int i = 1; i < 9; i++) begin
      step(0, 0, 0, 0, 1);
      checks++;
      if (obs_td !== 32'hB000_0000 + 32'(i)) begin
        errors++; $display("FAIL pp_drain_%0d got %h exp %h", i, obs_td, 32'hB000_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_bus_error;
    step(0, 1, 32'h0, 0, 0);
    checks++; if (obs_rd !== 32'd0) begin errors++; $display("FAIL unmapped_rdata got %h exp 0", obs_rd); end
    step(0, 0, 0, 0, 0);
    checks++; if (obs_be !== 1'b1) begin errors++; $display("FAIL unmapped_err got %b exp 1", obs_be); end
    step(1, 0, IB + 4, 32'h4, 0);
    step(1, 0, IB + 12, 32'hFFFF_FFFF, 0);
    checks++; if (obs_be !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", obs_be); end
    step(0, 0, 0, 0, 0);
    checks++; if (obs_be !== 1'b0) begin errors++; $display("FAIL rsvd_no_err got %b exp 0", obs_be); end
    step(1, 0, RB + 10, 32'h5555_5555, 0);
    step(0, 1, RB + 8, 0, 0);
    checks++; if (obs_be !== 1'b1) begin errors++; $display("FAIL misalign_err got %b exp 1", obs_be); end
    checks++; if (obs_rd !== 32'h1234_5678) begin errors++; $display("FAIL misalign_drop got %h exp 12345678", obs_rd); end
    step(1, 0, IB + 4, 32'h4, 0);
  endtask

  task automatic test_cycle_wrap;
    step(1, 0, IB + 8, 32'hFFFF_FFFE, 0);
    step(0, 1, IB + 8, 0, 0);
    checks++; if (obs_rd !== 32'hFFFF_FFFE) begin errors++; $display("FAIL cycle_load got %h exp fffffffe", obs_rd); end
    step(0, 1, IB + 8, 0, 0);
    checks++; if (obs_rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cycle_inc got %h exp ffffffff", obs_rd); end
    step(0, 1, IB + 8, 0, 0);
    checks++; if (obs_rd !== 32'd0) begin errors++; $display("FAIL cycle_wrap got %h exp 0", obs_rd); end
  endtask

  task automatic test_random;
    logic [31:0] a;
    int r;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r < 5)      a = RB + 32'(4 * $urandom_range(0, DD - 1));
      else if (r < 8) a = IB + 32'(4 * $urandom_range(0, 3));
      else if (r < 9) a = $urandom;
      else            a = RB + 32'(4 * $urandom_range(0, DD - 1)) + 32'($urandom_range(1, 3));
      step(($urandom % 3) == 0, $urandom % 2, a, $urandom, $urandom % 2);
      checks++;
      if (obs_tv !== exp_tv || obs_td !== exp_td) begin
        errors++; $display("FAIL rand_tx_%0d got v=%b d=%h exp v=%b d=%h", n, obs_tv, obs_td, exp_tv, exp_td);
      end
      checks++;
      if (obs_be !== exp_be) begin errors++; $display("FAIL rand_err_%0d got %b exp %b", n, obs_be, exp_be); end
      if (exp_def) begin
        checks++;
        if (obs_rd !== exp_rd) begin errors++; $display("FAIL rand_rd_%0d addr %h got %h exp %h", n, a, obs_rd, exp_rd); end
      end
    end
  endtask

  task automatic test_reset_mid_drain;
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, IB, 32'hC000_0000 + 32'(i), 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    checks++; if (obs_td !== 32'hC000_0001) begin errors++; $display("FAIL mid_drain got %h exp c0000001", obs_td); end
    reset = 1'b0;
    step(1, 0, IB, 32'hDDDD_0000, 1);
    step(0, 0, 0, 0, 1);
    checks++; if (obs_tv !== 1'b0 || obs_td !== 32'd0) begin errors++; $display("FAIL rst_drain_tx got v=%b d=%h exp v=0 d=0", obs_tv, obs_td); end
    reset = 1'b1;
    step(0, 1, IB, 0, 0);
    checks++; if (obs_rd !== 32'd0) begin errors++; $display("FAIL rst_drain_count got %0d exp 0", obs_rd); end
    step(0, 1, IB + 4, 0, 0);
    checks++; if (obs_rd !== 32'h1) begin errors++; $display("FAIL rst_drain_status got %h exp 1", obs_rd); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_ram();
    test_fifo_overflow();
    test_full_push_pop();
    test_bus_error();
    test_cycle_wrap();
    test_random();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
